seg_reg_hs: RTL and testbench

- Parametrised pipeline segment register for the RV32 pipeline, with a valid/ready handshake on both sides and an optional 2-entry skid buffer.
- Replaces the fixed-field en/clear stage registers. Each stage boundary carries a data payload (PC, operands, immediate) and a control payload (RegWrite, MemWrite, etc.).
- Adds synchronous flush with a guaranteed bubble, back-pressure without combinational ready paths (SKID=1), occupancy reporting and a saturating stall counter for performance debug.

---
 rtl/seg_reg_hs.sv | 135 +++++++++++++
 tb/tb_seg_reg_hs.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg_reg_hs.sv
// Pipeline segment register with valid/ready handshake on both sides, optional
// two-entry skid buffer, synchronous flush, occupancy and saturating stall counter.
module seg_reg_hs #(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 24,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              in_fire, out_fire;
  logic              load_m, load_s, m_from_s;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = m_data;
  // Gating keeps stale RegWrite/MemWrite bits from ever reaching downstream.
  assign out_ctrl  = out_valid ? m_ctrl : '0;

  always_comb begin
    if (SKID != 0) in_ready = (state_q != TWO) && !rst;
    else           in_ready = (!out_valid || out_ready) && !rst;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    load_m   = 1'b0;
    load_s   = 1'b0;
    m_from_s = 1'b0;
    occupancy = 2'd0;
    unique case (state_q)
      EMPTY: begin
        occupancy = 2'd0;
        if (in_fire) begin
          load_m  = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        occupancy = 2'd1;
        if (in_fire && out_fire) begin
          load_m = 1'b1;
        end else if (in_fire && (SKID != 0)) begin
          load_s  = 1'b1;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        occupancy = 2'd2;
        if (out_fire) begin
          m_from_s = 1'b1;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides any load decided above; the entry offered this cycle is lost.
    if (flush) begin
      state_d  = EMPTY;
      load_m   = 1'b0;
      load_s   = 1'b0;
      m_from_s = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: payload registers are reset explicitly; out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data <= '0;
      m_ctrl <= '0;
      s_data <= '0;
      s_ctrl <= '0;
    end else if (flush) begin
      m_ctrl <= '0;
      s_ctrl <= '0;
      if (CLEAR_DATA != 0) begin
        m_data <= '0;
        s_data <= '0;
      end
    end else begin
      if (load_m) begin
        m_data <= in_data;
        m_ctrl <= in_ctrl;
      end else if (m_from_s) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
      end
      if (load_s) begin
        s_data <= in_data;
        s_ctrl <= in_ctrl;
      end
    end
  end

  // Flush does not touch the counter; it measures downstream back-pressure only.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_seg_reg_hs.sv
// Directed bench for seg_reg_hs: a skid/clear-data instance with a 4-bit stall
// counter and a single-entry/hold-data instance, driven from one linear sequence.
module tb_seg_reg_hs;

  logic       clk;
  int         n_err;
  int         n_checks;

  logic       a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [3:0] a_in_ctrl, a_out_ctrl;
  logic [1:0] a_occ;
  logic [3:0] a_stall;

  logic       b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [3:0] b_in_ctrl, b_out_ctrl;
  logic [1:0] b_occ;
  logic [7:0] b_stall;

  seg_reg_hs #(.DATA_W(8), .CTRL_W(4), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  seg_reg_hs #(.DATA_W(8), .CTRL_W(4), .SKID(0), .CLEAR_DATA(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 1'b0;
    tick();
    tick();

    check("rst_in_ready", 32'(a_in_ready), 0);
    check("rst_valid", 32'(a_out_valid), 0);
    check("rst_data", 32'(a_out_data), 0);
    check("rst_ctrl", 32'(a_out_ctrl), 0);
    check("rst_occ", 32'(a_occ), 0);
    check("rst_stall", 32'(a_stall), 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(a_in_ready), 1);

    // Reset in the middle of a transfer
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_in_ctrl = 4'h3;
    tick();
    check("mid_data", 32'(a_out_data), 32'hA5);
    check("mid_ctrl", 32'(a_out_ctrl), 3);
    check("mid_occ", 32'(a_occ), 1);
    a_rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(a_in_ready), 0);
    tick();
    check("mid_rst_valid", 32'(a_out_valid), 0);
    check("mid_rst_data", 32'(a_out_data), 0);
    check("mid_rst_ctrl", 32'(a_out_ctrl), 0);
    check("mid_rst_occ", 32'(a_occ), 0);
    check("mid_rst_stall", 32'(a_stall), 0);
    a_rst = 1'b0; a_in_valid = 1'b0;

    // Streaming 1..8 with downstream always ready
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_data = 8'(i);
      a_in_ctrl = 4'(i);
      tick();
      check("stream_data", 32'(a_out_data), 32'(i));
      check("stream_ctrl", 32'(a_out_ctrl), 32'(i));
      check("stream_occ", 32'(a_occ), 1);
    end
    a_in_valid = 1'b0;
    tick();
    check("stream_drain_valid", 32'(a_out_valid), 0);
    check("stream_drain_ctrl", 32'(a_out_ctrl), 0);
    check("stream_stall", 32'(a_stall), 0);

    // Back-pressure fills the skid entry
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'd10; a_in_ctrl = 4'h1;
    tick();
    a_in_data = 8'd11; a_in_ctrl = 4'h2;
    tick();
    check("bp_occ", 32'(a_occ), 2);
    check("bp_in_ready", 32'(a_in_ready), 0);
    check("bp_head", 32'(a_out_data), 10);
    check("bp_head_ctrl", 32'(a_out_ctrl), 1);
    a_in_data = 8'd12; a_in_ctrl = 4'h4;
    tick();
    check("bp_hold_occ", 32'(a_occ), 2);
    check("bp_hold_data", 32'(a_out_data), 10);
    check("bp_hold_stall", 32'(a_stall), 2);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    check("bp_second", 32'(a_out_data), 11);
    check("bp_second_ctrl", 32'(a_out_ctrl), 2);
    check("bp_second_occ", 32'(a_occ), 1);
    check("bp_in_ready_back", 32'(a_in_ready), 1);
    tick();
    check("bp_empty", 32'(a_out_valid), 0);
    check("bp_stall_total", 32'(a_stall), 2);

    // Flush from TWO with a simultaneous offer
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'd20; a_in_ctrl = 4'h5;
    tick();
    a_in_data = 8'd21; a_in_ctrl = 4'h6;
    tick();
    check("fl_pre_occ", 32'(a_occ), 2);
    a_flush = 1'b1; a_in_data = 8'd22; a_in_ctrl = 4'h7;
    tick();
    check("fl_valid", 32'(a_out_valid), 0);
    check("fl_occ", 32'(a_occ), 0);
    check("fl_ctrl", 32'(a_out_ctrl), 0);
    check("fl_data_cleared", 32'(a_out_data), 0);
    a_flush = 1'b0; a_in_valid = 1'b0;
    tick();
    check("fl_bubble", 32'(a_out_valid), 0);
    check("fl_stall", 32'(a_stall), 4);

    // Stall counter saturation at 15
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h33; a_in_ctrl = 4'h9;
    tick();
    a_in_valid = 1'b0;
    repeat (10) tick();
    check("sat_stall_10", 32'(a_stall), 10);
    check("sat_hold_data", 32'(a_out_data), 32'h33);
    check("sat_hold_ctrl", 32'(a_out_ctrl), 9);
    repeat (10) tick();
    check("sat_stall_max", 32'(a_stall), 15);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("sat_flush_valid", 32'(a_out_valid), 0);
    check("sat_after_flush", 32'(a_stall), 15);

    // Single-entry variant: combinational ready, no bubble, data held on flush
    b_in_valid = 1'b1; b_in_data = 8'h40; b_in_ctrl = 4'h9;
    #1;
    check("b_empty_in_ready", 32'(b_in_ready), 1);
    tick();
    check("b_valid", 32'(b_out_valid), 1);
    check("b_occ", 32'(b_occ), 1);
    b_in_data = 8'h41; b_in_ctrl = 4'hA;
    #1;
    check("b_blocked_in_ready", 32'(b_in_ready), 0);
    tick();
    check("b_hold_data", 32'(b_out_data), 32'h40);
    b_out_ready = 1'b1;
    #1;
    check("b_comb_in_ready", 32'(b_in_ready), 1);
    tick();
    check("b_replace_data", 32'(b_out_data), 32'h41);
    check("b_replace_ctrl", 32'(b_out_ctrl), 32'hA);
    check("b_replace_valid", 32'(b_out_valid), 1);
    check("b_replace_occ", 32'(b_occ), 1);
    b_out_ready = 1'b0; b_flush = 1'b1; b_in_data = 8'h42; b_in_ctrl = 4'hB;
    tick();
    b_flush = 1'b0; b_in_valid = 1'b0;
    check("b_fl_valid", 32'(b_out_valid), 0);
    check("b_fl_ctrl", 32'(b_out_ctrl), 0);
    check("b_fl_data_held", 32'(b_out_data), 32'h41);
    check("b_fl_occ", 32'(b_occ), 0);
    check("b_stall", 32'(b_stall), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
